// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the derivation of the bit-counter width from the operand width.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Bit-counter width for a given operand width; the counter only has to
    // reach width-1, so $clog2(width) bits suffice (never less than one bit).
    function automatic int cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor: d = x - y - bin, with the borrow generated
// when the subtraction of this bit position needs to borrow from the next.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference and borrow of one bit position.
    always_comb begin
        d    = x ^ y ^ bin;
        bout = (~x & y) | (~(x ^ y) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, processed LSB first, one bit per clock
// through a single full-subtractor cell. Results appear on registered outputs
// that change only when an operation completes.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             ovf
);

    localparam int                 CNT_W    = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
    logic               bin_q, bin_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // Partial result: bits 0..WIDTH-2 accumulate here, the final bit is
    // merged straight into the result register on the completing edge.
    logic [WIDTH-2:0]   dsh_q, dsh_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               borrow_out_q, borrow_out_d;
    logic               ovf_q, ovf_d;

    logic               bit_d;
    logic               bit_bout;

    full_subtractor u_cell (
        .x    (a_sh_q[0]),
        .y    (b_sh_q[0]),
        .bin  (bin_q),
        .d    (bit_d),
        .bout (bit_bout)
    );

    // Next-state and datapath decisions for the IDLE -> RUN -> DONE sequence.
    always_comb begin
        // NOTE: every _d gets a default first so no path through the case
        // leaves it unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        a_sh_d       = a_sh_q;
        b_sh_d       = b_sh_q;
        a_msb_d      = a_msb_q;
        b_msb_d      = b_msb_q;
        bin_d        = bin_q;
        cnt_d        = cnt_q;
        dsh_d        = dsh_q;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;
        ovf_d        = ovf_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                    bin_d   = 1'b0;
                    cnt_d   = '0;
                end
            end

            ST_RUN: begin
                a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
                bin_d  = bit_bout;
                cnt_d  = cnt_q + CNT_ONE;

                dsh_d[WIDTH-2] = bit_d;
                for (int i = 0; i < WIDTH - 2; i++) begin
                    dsh_d[i] = dsh_q[i+1];
                end

                if (cnt_q == LAST_BIT) begin
                    state_d      = ST_DONE;
                    diff_d       = {bit_d, dsh_q};
                    borrow_out_d = bit_bout;
                    ovf_d        = (a_msb_q ^ b_msb_q) & (bit_d ^ a_msb_q);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous, active-high reset taking priority.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values of the others, independent of statement order.
        if (rst) begin
            state_q      <= ST_IDLE;
            a_sh_q       <= '0;
            b_sh_q       <= '0;
            a_msb_q      <= 1'b0;
            b_msb_q      <= 1'b0;
            bin_q        <= 1'b0;
            cnt_q        <= '0;
            dsh_q        <= '0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_sh_q       <= a_sh_d;
            b_sh_q       <= b_sh_d;
            a_msb_q      <= a_msb_d;
            b_msb_q      <= b_msb_d;
            bin_q        <= bin_d;
            cnt_q        <= cnt_d;
            dsh_q        <= dsh_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
            ovf_q        <= ovf_d;
        end
    end

    assign ready      = (state_q == ST_IDLE);
    assign busy       = (state_q == ST_RUN);
    assign done       = (state_q == ST_DONE);
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;
    assign ovf        = ovf_q;

endmodule
